// File: rtl/rsa_msg_sequencer.sv
// rsa_msg_sequencer: stream front-end for the RSA core.
// Buffers message words (each with its encrypt/decrypt flag) in a small FIFO,
// issues them one at a time to the core as a start pulse plus held operands,
// waits for the core's finish (bounded by a timeout) and returns each result,
// or an error marker, on a valid/ready output stream in input order.
module rsa_msg_sequencer #(
  parameter int WIDTH_MSG_I = 8,
  parameter int WIDTH_N     = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  // input message stream
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH_MSG_I-1:0] s_data,
  input  logic                   s_mode,
  // modulus, static while busy
  input  logic [WIDTH_N-1:0]     n_i,
  // core interface
  output logic [WIDTH_MSG_I-1:0] core_msg,
  output logic                   core_eORd,
  output logic                   core_start,
  input  logic [WIDTH_N-1:0]     core_result,
  input  logic                   core_finish,
  // result stream
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH_N-1:0]     m_data,
  output logic                   m_err,
  output logic                   busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int CMP_W = (WIDTH_MSG_I > WIDTH_N) ? WIDTH_MSG_I : WIDTH_N;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ARM,
    ST_START,
    ST_WAIT,
    ST_OUT
  } state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH_MSG_I-1:0] r_fifo_data [FIFO_DEPTH];
  logic                   r_fifo_mode [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [WIDTH_MSG_I-1:0] w_head_data;
  logic                   w_head_mode;

  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  // Held low while reset is applied so no word is accepted into a FIFO that
  // is being emptied.
  assign s_ready     = !reset && !w_full;
  assign w_push      = s_valid && s_ready;
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_head_mode = r_fifo_mode[r_rd_ptr];

  // Store pushed words; the storage itself carries no reset.
  // NOTE: memories are left unreset on purpose -- the pointers and count
  // define which entries are valid, so clearing the array adds nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= s_data;
      r_fifo_mode[r_wr_ptr] <= s_mode;
    end
  end

  // Maintain read/write pointers and occupancy; pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [WIDTH_MSG_I-1:0] r_core_msg;
  logic                   r_core_eord;
  logic                   r_core_start;
  logic [TMR_W-1:0]       r_timer;
  logic                   r_m_valid;
  logic [WIDTH_N-1:0]     r_m_data;
  logic                   r_m_err;

  logic [WIDTH_MSG_I-1:0] w_core_msg_nxt;
  logic                   w_core_eord_nxt;
  logic                   w_core_start_nxt;
  logic [TMR_W-1:0]       w_timer_nxt;
  logic                   w_m_valid_nxt;
  logic [WIDTH_N-1:0]     w_m_data_nxt;
  logic                   w_m_err_nxt;

  logic [CMP_W-1:0]       w_msg_ext;
  logic [CMP_W-1:0]       w_n_ext;
  logic                   w_reject;

  // A word is rejected when the modulus is degenerate or the word is not
  // strictly below it; both operands are compared zero-extended.
  assign w_msg_ext = CMP_W'(r_core_msg);
  assign w_n_ext   = CMP_W'(n_i);
  assign w_reject  = (w_n_ext < CMP_W'(2)) || (w_msg_ext >= w_n_ext);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next-output decode.
  // NOTE: every signal gets a default first, so no path through the case
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_pop            = 1'b0;
    w_core_msg_nxt   = r_core_msg;
    w_core_eord_nxt  = r_core_eord;
    w_core_start_nxt = 1'b0;
    w_timer_nxt      = r_timer;
    w_m_valid_nxt    = r_m_valid;
    w_m_data_nxt     = r_m_data;
    w_m_err_nxt      = r_m_err;

    unique case (r_state)
      ST_IDLE: begin
        // Launch the oldest buffered word once the output slot is free.
        if (!w_empty && !r_m_valid) begin
          w_pop           = 1'b1;
          w_core_msg_nxt  = w_head_data;
          w_core_eord_nxt = w_head_mode;
          w_state_nxt     = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (w_reject) begin
          w_m_data_nxt  = '0;
          w_m_err_nxt   = 1'b1;
          w_m_valid_nxt = 1'b1;
          w_state_nxt   = ST_OUT;
        end else begin
          w_state_nxt = ST_ARM;
        end
      end

      ST_ARM: begin
        // A finish still high from the previous operation must clear first,
        // otherwise it would be mistaken for this operation's completion.
        if (!core_finish) begin
          w_core_start_nxt = 1'b1;
          w_state_nxt      = ST_START;
        end
      end

      ST_START: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        w_timer_nxt = r_timer + TMR_W'(1);
        // Finish takes priority over a coincident timeout.
        if (core_finish) begin
          w_m_data_nxt  = core_result;
          w_m_err_nxt   = 1'b0;
          w_m_valid_nxt = 1'b1;
          w_state_nxt   = ST_OUT;
        end else if (r_timer == TMR_LAST) begin
          w_m_data_nxt  = '0;
          w_m_err_nxt   = 1'b1;
          w_m_valid_nxt = 1'b1;
          w_state_nxt   = ST_OUT;
        end
      end

      ST_OUT: begin
        // Result is held until the downstream accepts it.
        if (m_ready) begin
          w_m_valid_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered core operands, start pulse, timer and result stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_core_msg   <= '0;
      r_core_eord  <= 1'b0;
      r_core_start <= 1'b0;
      r_timer      <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_err      <= 1'b0;
    end else begin
      r_core_msg   <= w_core_msg_nxt;
      r_core_eord  <= w_core_eord_nxt;
      r_core_start <= w_core_start_nxt;
      r_timer      <= w_timer_nxt;
      r_m_valid    <= w_m_valid_nxt;
      r_m_data     <= w_m_data_nxt;
      r_m_err      <= w_m_err_nxt;
    end
  end

  assign core_msg   = r_core_msg;
  assign core_eORd  = r_core_eord;
  assign core_start = r_core_start;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_err      = r_m_err;
  assign busy       = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_rsa_msg_sequencer.sv
// Self-checking bench for rsa_msg_sequencer: a behavioural core model, a
// queue-based expectation model, one per-cycle compare process, and directed
// plus randomized phases.
module tb_rsa_msg_sequencer;

  localparam int W     = 8;
  localparam int WN    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 4096;
  localparam int E_KEY = 3;
  localparam int D_KEY = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_mode;
  logic [WN-1:0] n_i;
  logic [W-1:0]  core_msg;
  logic          core_eORd;
  logic          core_start;
  logic [WN-1:0] core_result;
  logic          core_finish;
  logic          m_valid;
  logic          m_ready;
  logic [WN-1:0] m_data;
  logic          m_err;
  logic          busy;

  always #5 clk = ~clk;

  rsa_msg_sequencer #(
    .WIDTH_MSG_I(W),
    .WIDTH_N    (WN),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_mode     (s_mode),
    .n_i        (n_i),
    .core_msg   (core_msg),
    .core_eORd  (core_eORd),
    .core_start (core_start),
    .core_result(core_result),
    .core_finish(core_finish),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_err      (m_err),
    .busy       (busy)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping and model state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { int data; int err; } res_t;
  typedef struct { int msg;  int mode; } launch_t;

  res_t    exp_q[$];
  launch_t launch_q[$];

  int n_val       = 0;  // modulus currently applied
  int core_mode   = 0;  // 0 normal, 1 never finishes, 2 finish stuck high
  int lat_min     = 1;
  int lat_max     = 6;
  int ready_mode  = 0;  // 0 hold low, 1 hold high, 2 random
  int start_count = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic int modexp(input int b, input int e, input int m);
    int r = 1;
    int bb = b % m;
    for (int i = 0; i < e; i++) r = (r * bb) % m;
    return r;
  endfunction

  function automatic bit word_ok(input int w);
    return (n_val >= 2) && (w < n_val);
  endfunction

  // What the sequencer must return for a word, given the modulus and the
  // behaviour the core model is currently set to.
  function automatic res_t expect_of(input int w, input int mode);
    res_t r;
    if (!word_ok(w) || core_mode == 1) begin
      r.data = 0;
      r.err  = 1;
    end else begin
      r.data = modexp(w, mode ? E_KEY : D_KEY, n_val);
      r.err  = 0;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Core model: result = msg^key mod n after a random latency; finish is a
  // level held for a few cycles afterwards.
  // ---------------------------------------------------------------------------
  initial begin
    int lat  = 0;
    int hold = 0;
    bit pend = 1'b0;
    int cm   = 0;
    int cd   = 0;
    core_finish = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_mode == 2) begin
        core_finish = 1'b1;
        pend = 1'b0;
        hold = 0;
      end else if (core_mode == 1) begin
        core_finish = 1'b0;
        pend = 1'b0;
      end else begin
        if (core_finish) begin
          if (hold > 0) hold--;
          else core_finish = 1'b0;
        end
        if (core_start && !reset) begin
          pend = 1'b1;
          lat  = $urandom_range(lat_max, lat_min);
          cm   = int'(core_msg);
          cd   = int'(core_eORd);
        end else if (pend) begin
          if (lat > 0) lat--;
          else begin
            pend        = 1'b0;
            core_finish = 1'b1;
            core_result = WN'(modexp(cm, cd ? E_KEY : D_KEY, n_val));
            hold        = $urandom_range(3, 0);
          end
        end
      end
    end
  end

  // Downstream ready driver.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every launch and every valid output cycle is checked
  // against the model queues.
  // ---------------------------------------------------------------------------
  initial begin
    bit prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && chk_en) begin
        if (core_start) begin
          start_count++;
          check("start_single_cycle", int'(prev_start), 0);
          check("launch_expected", int'(launch_q.size() > 0), 1);
          if (launch_q.size() > 0) begin
            check("launch_msg",  int'(core_msg),  launch_q[0].msg);
            check("launch_mode", int'(core_eORd), launch_q[0].mode);
            void'(launch_q.pop_front());
          end
        end
        if (m_valid) begin
          check("result_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            check("m_data", int'(m_data), exp_q[0].data);
            check("m_err",  int'(m_err),  exp_q[0].err);
            if (m_ready) void'(exp_q.pop_front());
          end
        end
      end
      prev_start = core_start;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (push is called aligned to posedge+1)
  // ---------------------------------------------------------------------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int w, input int mode);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = W'(w);
    s_mode  = 1'(mode);
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (s_ready) begin
        exp_q.push_back(expect_of(w, mode));
        if (word_ok(w)) begin
          launch_t l;
          l.msg  = w;
          l.mode = mode;
          launch_q.push_back(l);
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("push_accepted", int'(done), 1);
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input string name, input int max, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!m_valid && c < max);
    check(name, int'(m_valid), 1);
  endtask

  task automatic wait_start(input string name, input int max);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!core_start && c < max);
    check(name, int'(core_start), 1);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 5000 && exp_q.size() > 0; t++) @(negedge clk);
    check(name, exp_q.size(), 0);
    sync();
  endtask

  task automatic set_n(input int n);
    n_val = n;
    n_i   = WN'(n);
  endtask

  // Watchdog: a hung run still ends with a report.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int c;
    int s0;
    int mv;
    int got[$];

    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_mode  = 1'b0;
    n_i     = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready",    int'(s_ready),    0);
    check("rst_m_valid",    int'(m_valid),    0);
    check("rst_core_start", int'(core_start), 0);
    check("rst_core_msg",   int'(core_msg),   0);
    check("rst_core_eord",  int'(core_eORd),  0);
    check("rst_m_data",     int'(m_data),     0);
    check("rst_m_err",      int'(m_err),      0);
    check("rst_busy",       int'(busy),       0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", int'(s_ready), 1);
    sync();

    // Encrypt 4 with e=3 mod 33 -> 31; output held while m_ready is low.
    set_n(33);
    ready_mode = 0;
    s0 = start_count;
    push(4, 1);
    wait_mvalid("t1_mvalid", 100, c);
    check("t1_data",   int'(m_data), 31);
    check("t1_err",    int'(m_err),  0);
    check("t1_starts", start_count - s0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_hold_valid", int'(m_valid), 1);
      check("t1_hold_data",  int'(m_data),  31);
    end
    ready_mode = 1;
    drain("t1_drain");

    // Decrypt 31 with d=7 -> 4, then two words back-to-back keep order.
    push(31, 0);
    wait_mvalid("t2_mvalid", 100, c);
    check("t2_data", int'(m_data), 4);
    sync();
    push(4, 1);
    push(31, 0);
    got.delete();
    for (int t = 0; t < 300 && got.size() < 2; t++) begin
      @(negedge clk);
      if (m_valid && m_ready) got.push_back(int'(m_data));
    end
    check("t2_order_count", got.size(), 2);
    if (got.size() == 2) begin
      check("t2_order_first",  got[0], 31);
      check("t2_order_second", got[1], 4);
    end
    drain("t2_drain");

    // Out-of-range words are rejected without starting the core.
    s0 = start_count;
    push(40, 1);
    wait_mvalid("t3_mvalid_40", 10, c);
    check("t3_reject_latency_ok", int'(c <= 3), 1);
    check("t3_40_data", int'(m_data), 0);
    check("t3_40_err",  int'(m_err),  1);
    drain("t3_drain_40");
    push(33, 1);
    wait_mvalid("t3_mvalid_33", 10, c);
    check("t3_33_err", int'(m_err), 1);
    check("t3_no_start", start_count - s0, 0);
    drain("t3_drain_33");
    push(32, 1);
    wait_mvalid("t3_mvalid_32", 100, c);
    check("t3_32_data", int'(m_data), 32);
    check("t3_32_err",  int'(m_err),  0);
    drain("t3_drain_32");

    // Fill: one word in flight plus four buffered blocks the input.
    ready_mode = 0;
    sync();
    for (int i = 0; i < 5; i++) push($urandom_range(32, 0), $urandom_range(1, 0));
    repeat (3) @(negedge clk);
    check("t4_s_ready_full", int'(s_ready), 0);
    check("t4_busy",         int'(busy),    1);
    ready_mode = 1;
    sync();
    push($urandom_range(32, 0), $urandom_range(1, 0));
    drain("t4_drain");

    // Core never finishes -> error after the timeout; next word is normal.
    core_mode = 1;
    push(10, 1);
    wait_start("t5_start", 100);
    wait_mvalid("t5_mvalid", TMO + 50, c);
    check("t5_timeout_cycles", c, TMO + 1);
    check("t5_err", int'(m_err), 1);
    drain("t5_drain");
    core_mode = 0;
    push(5, 1);
    wait_mvalid("t5_next_mvalid", 100, c);
    check("t5_next_data", int'(m_data), 26);
    drain("t5_next_drain");

    // Finish stuck high -> parked before start; released -> normal result.
    core_mode = 2;
    repeat (2) sync();
    s0 = start_count;
    push(7, 1);
    mv = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_valid) mv++;
    end
    check("t6_no_start",  start_count - s0, 0);
    check("t6_no_mvalid", mv, 0);
    check("t6_busy",      int'(busy), 1);
    sync();
    core_mode = 0;
    wait_mvalid("t6_mvalid", 100, c);
    check("t6_data", int'(m_data), 13);
    drain("t6_drain");

    // Reset during WAIT with two words buffered.
    lat_min = 40;
    lat_max = 40;
    push(2, 1);
    push(3, 1);
    push(6, 0);
    wait_start("t7_start", 100);
    repeat (5) @(negedge clk);
    sync();
    reset  = 1'b1;
    chk_en = 1'b0;
    exp_q.delete();
    launch_q.delete();
    @(negedge clk);
    check("t7_rst_s_ready", int'(s_ready), 0);
    sync();
    reset = 1'b0;
    @(negedge clk);
    check("t7_m_valid",    int'(m_valid),    0);
    check("t7_core_start", int'(core_start), 0);
    check("t7_core_msg",   int'(core_msg),   0);
    check("t7_core_eord",  int'(core_eORd),  0);
    check("t7_m_data",     int'(m_data),     0);
    check("t7_m_err",      int'(m_err),      0);
    check("t7_busy",       int'(busy),       0);
    check("t7_s_ready",    int'(s_ready),    1);
    chk_en = 1'b1;
    mv = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m_valid) mv++;
    end
    check("t7_no_mvalid", mv, 0);
    lat_min = 1;
    lat_max = 6;
    sync();
    push(8, 0);
    wait_mvalid("t7_new_mvalid", 200, c);
    check("t7_new_data", int'(m_data), 2);
    drain("t7_new_drain");

    // Randomized rounds, each with its own modulus.
    for (int r = 0; r < 5; r++) begin
      int nsel;
      case (r)
        0:       nsel = 1;
        1:       nsel = 2;
        2:       nsel = 17;
        default: nsel = $urandom_range(255, 3);
      endcase
      set_n(nsel);
      ready_mode = 2;
      for (int i = 0; i < 25; i++) begin
        int w;
        int hi = (n_val + 2 > 255) ? 255 : n_val + 2;
        w = ($urandom_range(3, 0) == 0) ? $urandom_range(255, 0) : $urandom_range(hi, 0);
        push(w, $urandom_range(1, 0));
        repeat ($urandom_range(2, 0)) sync();
      end
      ready_mode = 1;
      drain("rand_drain");
    end

    check("final_launch_q_empty", launch_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
